// File: rtl/rx_bank_buff.sv
// Multi-bank receive buffer: a MAC-side writer fills 2**BW banks in ring order and a DMA-side reader drains and releases them.
// Optional feature: define RX_BANK_BUFF_DROP_CNT_EN to build the saturating dropped-word counter.
module rx_bank_buff #(
    parameter int DW  = 64,
    parameter int BAW = 9,
    parameter int BW  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    output logic          wr_free,
    output logic          rd_avail,
    output logic [BAW:0]  rd_len,
    input  logic [BAW-1:0] rd_addr,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_vld,
    input  logic          rd_release,
    output logic [31:0]   drop_cnt
);

    localparam int NB    = 2 ** BW;
    localparam int DEPTH = 2 ** (BW + BAW);
    localparam int AW    = BW + BAW;

    logic [DW-1:0]  mem [DEPTH];
    logic [NB-1:0]  closed;
    logic [BAW:0]   len_q [NB];

    logic [BW-1:0]  wr_ptr;
    logic [BW-1:0]  rd_ptr;
    logic [BAW-1:0] wr_off;

    logic           wq_en;
    logic           wq_close;
    logic [AW-1:0]  wq_addr;
    logic [DW-1:0]  wq_data;
    logic [BAW:0]   wq_len;

    logic           rel_q;
    logic [BW-1:0]  rel_bank;

    logic           rq_en;
    logic           rq_vld;
    logic [BW-1:0]  rq_bank;
    logic [BAW-1:0] rq_addr;

    logic           wr_acc;
    logic           wr_close;
    logic           rel_ok;

    assign wr_free  = ~closed[wr_ptr];
    assign rd_avail = closed[rd_ptr];
    assign rd_len   = rd_avail ? len_q[rd_ptr] : '0;

    assign wr_acc   = wr_en & wr_free;
    assign wr_close = wr_acc & (wr_last | (&wr_off));
    assign rel_ok   = rd_release & rd_avail;

    // Control state. A bank turns CLOSED only once its last word is committed,
    // and turns FREE one cycle after the release so in-flight reads finish first.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register here sees the pre-edge value of every other register.
            closed      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_off      <= '0;
            wq_en       <= 1'b0;
            wq_close    <= 1'b0;
            rel_q       <= 1'b0;
            rq_en       <= 1'b0;
            rq_vld      <= 1'b0;
            rd_data_vld <= 1'b0;
            rd_data     <= '0;
        end else begin
            wq_en    <= wr_acc;
            wq_close <= wr_close;
            if (wr_acc) begin
                if (wr_close) begin
                    wr_ptr <= wr_ptr + BW'(1);
                    wr_off <= '0;
                end else begin
                    wr_off <= wr_off + BAW'(1);
                end
            end

            rel_q <= rel_ok;
            if (rel_ok)
                rd_ptr <= rd_ptr + BW'(1);

            // Close and free always target different banks, so both may apply.
            if (wq_close)
                closed[wq_addr[AW-1:BAW]] <= 1'b1;
            if (rel_q)
                closed[rel_bank] <= 1'b0;

            rq_en       <= rd_en;
            rq_vld      <= rd_en & rd_avail;
            rd_data_vld <= rq_vld;
            if (rq_en)
                rd_data <= mem[{rq_bank, rq_addr}];
        end
    end

    // Datapath registers carry no reset; their enables are qualified by reset state.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            wq_addr <= {wr_ptr, wr_off};
            wq_data <= wr_data;
            wq_len  <= {1'b0, wr_off} + (BAW + 1)'(1);
        end
        rel_bank <= rd_ptr;
        rq_bank  <= rd_ptr;
        rq_addr  <= rd_addr;
        if (wq_close)
            len_q[wq_addr[AW-1:BAW]] <= wq_len;
    end

    // NOTE: the RAM array is never reset; clearing it would block RAM inference
    // and the bank state bits already hide stale contents from the reader.
    always_ff @(posedge clk) begin
        if (wq_en)
            mem[wq_addr] <= wq_data;
    end

`ifdef RX_BANK_BUFF_DROP_CNT_EN
    logic [31:0] drop_q;

    always_ff @(posedge clk) begin
        if (reset)
            drop_q <= '0;
        else if (wr_en && !wr_free && (drop_q != '1))
            drop_q <= drop_q + 32'd1;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: doc/rx_bank_buff.md
# rx_bank_buff

Parametrised multi-bank receive buffer; the next generation of the two-bank RX buffer, with 2**BW banks instead of a fixed two. It sits between the MAC-side receive logic and the PCIe DMA engine. It adds per-bank ownership tracking, so the writer fills banks in ring order and the reader drains and releases closed banks. It runs on one clock with registered write and read paths inferring block RAM.

## Interface
- DW, 64, data word width in bits
- BAW, 9, bank address width; each bank holds 2**BAW words
- BW, 1, bank index width; 2**BW banks, BW ≥ 1
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe
- wr_data  in  DW  write word
- wr_last  in  1  with wr_en: this word closes the current bank
- wr_free  out  1  bank at write pointer is free; writes are accepted
- rd_avail  out  1  bank at read pointer is closed and readable
- rd_len  out  BAW+1  word count of the readable bank, 1..2**BAW; valid while rd_avail
- rd_addr  in  BAW  word offset within the readable bank
- rd_en  in  1  read strobe
- rd_data  out  DW  read word
- rd_data_vld  out  1  rd_data valid this cycle
- rd_release  in  1  return the readable bank to the writer
- drop_cnt  out  32  words dropped for lack of a free bank

## Operation
- Storage: 2**BW × 2**BAW words of DW bits. Per bank: state bit (FREE/CLOSED) and length register (BAW+1 bits).
- Pointers: wr_ptr and rd_ptr (BW bits) wrap modulo 2**BW. wr_off (BAW bits) is the next write offset.
- Accept: a write is accepted iff wr_en and wr_free. The word lands at bank wr_ptr, offset wr_off. wr_off increments.
- Close: an accepted write with wr_last=1, or with wr_off = 2**BAW−1 (auto-close, full bank), closes the bank.
  - len = wr_off+1; wr_ptr increments; wr_off clears.
- Drop: wr_en with wr_free=0 discards the word. No state changes except drop_cnt.
- A bank never partially visible: the reader sees a bank only after it closes.
- Read: rd_en reads offset rd_addr of bank rd_ptr (bank index latched at issue). rd_data_vld=1 iff rd_avail was 1 at issue. rd_addr ≥ rd_len returns stale data and still flags valid; the reader bounds addresses.
- Release: rd_release with rd_avail=1 increments rd_ptr next cycle. The bank state returns to FREE two cycles after the release, so reads issued up to the release cycle complete from the old contents. rd_release with rd_avail=0 is ignored.
- Reset clears all bank states to FREE, both pointers, wr_off and drop_cnt. RAM contents are not cleared.

## Timing
- Reset values: wr_free=1, rd_avail=0, rd_len=0, rd_data=0, rd_data_vld=0, drop_cnt=0.
- Write path is registered once (address/data register), then committed to RAM at the following edge.
- Closing write at cycle N: commits at the edge ending N+1. Bank state is CLOSED and rd_avail=1 from N+2 when that bank is at rd_ptr.
- wr_free reflects the state of bank wr_ptr combinationally from registers. After a close it reflects the next bank from N+1.
- Read latency is 2 cycles: rd_en at N gives rd_data and rd_data_vld at N+2. Throughput is one read per cycle.
- Release at N: rd_ptr advances at N+1, and rd_avail/rd_len show the next bank from N+1. The released bank reads FREE to the writer from N+2.
- Simultaneous close and release on different banks both take effect. With 2**BW=2 and both banks cycling, there is no lost update.
- Write to a bank whose read is still in flight cannot occur: the 2-cycle release hold-off covers the read latency.

## Configuration
- RX_BANK_BUFF_DROP_CNT_EN defined: drop_cnt counts each dropped wr_en, saturating at 2**32−1, cleared by reset.
- Undefined: the counter is not built and drop_cnt is constant 0.

## Test plan
- Reset, then write 5 words 0x11..0x15 with wr_last on the 5th: rd_avail=1 from 2 cycles after the last write, rd_len=5. Reads at offsets 0..4 return 0x11..0x15 at +2 cycles with rd_data_vld.
- Write 2**BAW words without wr_last: auto-close occurs with rd_len=2**BAW. The next write lands in bank 1 at offset 0.
- BW=1: fill both banks without releasing, then issue 3 more writes: wr_free=0, all 3 are dropped, drop_cnt=3 (0 with the macro undefined), bank contents are unchanged.
- Release bank 0 and issue rd_en in the same cycle: the read returns the old bank-0 word. wr_free rises 2 cycles after the release, and the next write lands in bank 0.
- Cycle four banks (BW=2) twice with lengths 1,7,3,2**BAW: the pointers wrap, and each rd_len and data pattern matches.
- Assert reset mid-fill and mid-read: the next cycle shows wr_free=1, rd_avail=0, rd_data_vld=0, drop_cnt=0. The next bank written is bank 0.
